data_island_scheduler: RTL

Sequences HDMI data islands inside blanking and shares the packet slots between packet sources (ACR, audio sample, InfoFrames).
- Decides when an island may start, emits preamble/guard/period framing, and drives the packet_enable/packet_pixel_counter strobe consumed by the packet mux.
- Runs a fixed-priority arbiter at each packet boundary.
- Sits between the video timing generator and the packet mux/TERC4 encoder.

---
 rtl/hdmi_island_pkg.sv | 27 ++
 rtl/fixed_priority_arbiter.sv | 28 ++
 rtl/data_island_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_island_pkg.sv
// Shared state encoding and framing constants for the HDMI data-island scheduler.
package hdmi_island_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_LEAD_GUARD,
    ST_PACKET,
    ST_TRAIL_GUARD,
    ST_GAP
  } island_state_t;

  localparam int PREAMBLE_LEN           = 8;
  localparam int GUARD_LEN              = 2;
  localparam int PACKET_LEN             = 32;
  localparam int MAX_PACKETS_PER_ISLAND = 18;

  localparam int ISLAND_MIN_LEN = PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN;
  // The counter-31 cycle itself, one more packet, and the trailing guard.
  localparam int CONTINUE_MIN   = 1 + PACKET_LEN + GUARD_LEN;

  // States in which active video is a timing violation.
  function automatic logic in_island(input island_state_t s);
    return s inside {ST_PREAMBLE, ST_LEAD_GUARD, ST_PACKET, ST_TRAIL_GUARD};
  endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Combinational fixed-priority arbiter: lowest set request index wins.
module fixed_priority_arbiter #(
  parameter int REQ_COUNT = 4,
  parameter int IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic [REQ_COUNT-1:0] req,
  output logic [REQ_COUNT-1:0] grant,
  output logic [IDX_W-1:0]     index,
  output logic                 valid
);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    // Scan from the top so the lowest set index is the one left standing.
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_island_scheduler.sv
// Schedules HDMI data islands inside blanking and hands packet slots to requesters.
module data_island_scheduler
  import hdmi_island_pkg::*;
#(
  parameter int  REQ_COUNT    = 4,
  parameter int  BLANK_WIDTH  = 12,
  parameter int  TAIL_RESERVE = 12,
  parameter int  ISLAND_GAP   = 12,
  localparam int IDX_W        = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   video_data_period,
  input  logic [BLANK_WIDTH-1:0] blank_cycles_left,
  input  logic [REQ_COUNT-1:0]   req,
  output logic [REQ_COUNT-1:0]   grant,
  output logic [IDX_W-1:0]       packet_index,
  output logic                   packet_null,
  output logic                   packet_enable,
  output logic [4:0]             packet_pixel_counter,
  output logic                   data_island_preamble,
  output logic                   data_island_guard,
  output logic                   data_island_period,
  output logic                   overrun
);

  localparam int GAP_W   = (ISLAND_GAP > 1) ? $clog2(ISLAND_GAP) : 1;
  localparam int PHASE_W = (GAP_W > 5) ? GAP_W : 5;
  localparam int CMP_W   = BLANK_WIDTH + 1;

  localparam logic [CMP_W-1:0] ENTRY_MIN = CMP_W'(ISLAND_MIN_LEN + TAIL_RESERVE);
  // Continuation is decided at counter 30, when blank_cycles_left is one higher.
  localparam logic [CMP_W-1:0] CONT_MIN_AHEAD = CMP_W'(CONTINUE_MIN + TAIL_RESERVE + 1);

  localparam logic [PHASE_W-1:0] PRE_LAST      = PHASE_W'(PREAMBLE_LEN - 1);
  localparam logic [PHASE_W-1:0] GUARD_LAST    = PHASE_W'(GUARD_LEN - 1);
  localparam logic [PHASE_W-1:0] GUARD_PRELAST = PHASE_W'(GUARD_LEN - 2);
  localparam logic [PHASE_W-1:0] PKT_LAST      = PHASE_W'(PACKET_LEN - 1);
  localparam logic [PHASE_W-1:0] PKT_PRELAST   = PHASE_W'(PACKET_LEN - 2);
  localparam logic [PHASE_W-1:0] GAP_LAST      = PHASE_W'(ISLAND_GAP - 1);

  island_state_t        state, state_next;
  logic [PHASE_W-1:0]   cnt, cnt_next;
  logic                 continue_q;
  logic [4:0]           packets_in_island;
  logic [IDX_W-1:0]     pend_index;
  logic                 pend_null;

  logic [REQ_COUNT-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_index;
  logic                 arb_valid;

  logic [CMP_W-1:0]     blank_ext;
  logic                 abort;
  logic                 cont_ok;
  logic                 boundary;

  logic [REQ_COUNT-1:0] grant_d;
  logic                 enable_d;
  logic                 preamble_d;
  logic                 guard_d;
  logic                 period_d;
  logic [4:0]           pixel_d;

  fixed_priority_arbiter #(
    .REQ_COUNT (REQ_COUNT),
    .IDX_W     (IDX_W)
  ) u_arbiter (
    .req   (req),
    .grant (arb_grant),
    .index (arb_index),
    .valid (arb_valid)
  );

  assign blank_ext = {1'b0, blank_cycles_left};
  assign abort     = video_data_period && in_island(state);

  // Evaluated one cycle early so grant/packet_enable can be registered onto counter 31.
  assign cont_ok = (state == ST_PACKET) && (cnt == PKT_PRELAST) && (|req) &&
                   (packets_in_island < 5'(MAX_PACKETS_PER_ISLAND)) &&
                   (blank_ext >= CONT_MIN_AHEAD) && !abort;

  assign boundary = !abort &&
                    (((state == ST_LEAD_GUARD) && (cnt == GUARD_PRELAST)) || cont_ok);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      continue_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      continue_q <= cont_ok;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (!video_data_period && (|req) && (blank_ext >= ENTRY_MIN))
          state_next = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (cnt == PRE_LAST) begin
          state_next = ST_LEAD_GUARD;
          cnt_next   = '0;
        end
      end
      ST_LEAD_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_next = ST_PACKET;
          cnt_next   = '0;
        end
      end
      ST_PACKET: begin
        if (cnt == PKT_LAST) begin
          state_next = continue_q ? ST_PACKET : ST_TRAIL_GUARD;
          cnt_next   = '0;
        end
      end
      ST_TRAIL_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    grant_d    = boundary ? arb_grant : '0;
    enable_d   = boundary;
    preamble_d = (state_next == ST_PREAMBLE);
    guard_d    = (state_next == ST_LEAD_GUARD) || (state_next == ST_TRAIL_GUARD);
    period_d   = (state_next == ST_PACKET);
    pixel_d    = period_d ? cnt_next[4:0] : 5'd0;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      grant                <= '0;
      packet_enable        <= 1'b0;
      data_island_preamble <= 1'b0;
      data_island_guard    <= 1'b0;
      data_island_period   <= 1'b0;
      packet_pixel_counter <= 5'd0;
      packet_index         <= '0;
      packet_null          <= 1'b0;
      overrun              <= 1'b0;
      pend_index           <= '0;
      pend_null            <= 1'b0;
      packets_in_island    <= 5'd0;
    end else begin
      grant                <= grant_d;
      packet_enable        <= enable_d;
      data_island_preamble <= preamble_d;
      data_island_guard    <= guard_d;
      data_island_period   <= period_d;
      packet_pixel_counter <= pixel_d;
      overrun              <= overrun | abort;

      if (boundary) begin
        pend_index <= arb_index;
        pend_null  <= !arb_valid;
      end

      // Packet owner becomes visible on counter 0, one cycle after the grant.
      if (packet_enable && (state_next == ST_PACKET)) begin
        packet_index <= pend_index;
        packet_null  <= pend_null;
      end else if (state_next != ST_PACKET) begin
        packet_null <= 1'b0;
      end

      if (state == ST_IDLE)
        packets_in_island <= 5'd0;
      else if (boundary)
        packets_in_island <= packets_in_island + 1'b1;
    end
  end

endmodule
